// File: rtl/rram_row_sequencer_if.sv
// Request, array-drive and completion signals between a requester and rram_row_sequencer.
interface rram_row_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [4:0] req_row;
  logic       dec_en;
  logic [4:0] dec_din;
  logic [1:0] bl_mode;
  logic       sa_strobe;
  logic       sa_data;
  logic       done_valid;
  logic       done_status;
  logic       rd_data;
  logic [1:0] done_retries;

  modport master (
    output req_valid, req_op, req_row, sa_data,
    input  req_ready, dec_en, dec_din, bl_mode, sa_strobe,
           done_valid, done_status, rd_data, done_retries
  );

  modport slave (
    input  req_valid, req_op, req_row, sa_data,
    output req_ready, dec_en, dec_din, bl_mode, sa_strobe,
           done_valid, done_status, rd_data, done_retries
  );
endinterface

// File: rtl/rram_row_sequencer.sv
// Single-row RRAM access sequencer: SETUP -> PULSE -> HOLD -> DONE with programmable timing.
// Define RRAM_WRITE_VERIFY_EN to add a verify read and bounded retry after SET/RESET.
module rram_row_sequencer #(
  parameter int SETUP_CYC = 2,
  parameter int READ_CYC  = 4,
  parameter int SET_CYC   = 8,
  parameter int RESET_CYC = 8,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 8,
  parameter int MAX_RETRY = 3
) (
  input logic clk,
  input logic rst_n,
  rram_row_sequencer_if.slave bus
);
  localparam logic [1:0] OP_NOP = 2'b00, OP_READ = 2'b01, OP_SET = 2'b10;

  // Zero-length phases are stretched to one cycle so the timer never underflows.
  localparam int SETUP_N = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
  localparam int READ_N  = (READ_CYC  == 0) ? 1 : READ_CYC;
  localparam int SET_N   = (SET_CYC   == 0) ? 1 : SET_CYC;
  localparam int RESET_N = (RESET_CYC == 0) ? 1 : RESET_CYC;
  localparam int HOLD_N  = (HOLD_CYC  == 0) ? 1 : HOLD_CYC;

  if (SETUP_N >= 2**CNT_W || READ_N >= 2**CNT_W || SET_N >= 2**CNT_W ||
      RESET_N >= 2**CNT_W || HOLD_N >= 2**CNT_W || MAX_RETRY >= 2**CNT_W) begin : g_param_chk
    $error("rram_row_sequencer: timing/retry parameter does not fit CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE
`ifdef RRAM_WRITE_VERIFY_EN
    , S_VSETUP, S_VPULSE, S_VHOLD
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       row_q, row_d;
  logic             rd_q, rd_d;
  logic             last_cyc;

  function automatic logic [CNT_W-1:0] pulse_ld(input logic [1:0] op);
    case (op)
      OP_READ: pulse_ld = CNT_W'(READ_N - 1);
      OP_SET:  pulse_ld = CNT_W'(SET_N - 1);
      default: pulse_ld = CNT_W'(RESET_N - 1);
    endcase
  endfunction

  assign last_cyc = (cnt_q == '0);

`ifdef RRAM_WRITE_VERIFY_EN
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             status_q, status_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      row_q   <= '0;
      rd_q    <= 1'b0;
`ifdef RRAM_WRITE_VERIFY_EN
      retry_q  <= '0;
      status_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      row_q   <= row_d;
      rd_q    <= rd_d;
`ifdef RRAM_WRITE_VERIFY_EN
      retry_q  <= retry_d;
      status_q <= status_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = last_cyc ? cnt_q : cnt_q - 1'b1;
    op_d    = op_q;
    row_d   = row_q;
    rd_d    = rd_q;
`ifdef RRAM_WRITE_VERIFY_EN
    retry_d  = retry_q;
    status_d = status_q;
`endif
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d  = bus.req_op;
        row_d = bus.req_row;
`ifdef RRAM_WRITE_VERIFY_EN
        retry_d  = '0;
        status_d = 1'b0;
`endif
        if (bus.req_op == OP_NOP) state_d = S_DONE;
        else begin
          state_d = S_SETUP;
          cnt_d   = CNT_W'(SETUP_N - 1);
        end
      end
      S_SETUP: if (last_cyc) begin
        state_d = S_PULSE;
        cnt_d   = pulse_ld(op_q);
      end
      S_PULSE: if (last_cyc) begin
        if (op_q == OP_READ) rd_d = bus.sa_data;
        state_d = S_HOLD;
        cnt_d   = CNT_W'(HOLD_N - 1);
      end
      S_HOLD: if (last_cyc) begin
`ifdef RRAM_WRITE_VERIFY_EN
        if (op_q != OP_READ) begin
          state_d = S_VSETUP;
          cnt_d   = CNT_W'(SETUP_N - 1);
        end else
`endif
          state_d = S_DONE;
      end
`ifdef RRAM_WRITE_VERIFY_EN
      S_VSETUP: if (last_cyc) begin
        state_d = S_VPULSE;
        cnt_d   = CNT_W'(READ_N - 1);
      end
      S_VPULSE: if (last_cyc) begin
        rd_d    = bus.sa_data;
        state_d = S_VHOLD;
        cnt_d   = CNT_W'(HOLD_N - 1);
      end
      // A SET cell should read back 1, a RESET cell 0.
      S_VHOLD: if (last_cyc) begin
        if (rd_q == (op_q == OP_SET)) begin
          state_d = S_DONE;
        end else if (retry_q < CNT_W'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_SETUP;
          cnt_d   = CNT_W'(SETUP_N - 1);
        end else begin
          status_d = 1'b1;
          state_d  = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops the word line at once.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.done_valid = (state_q == S_DONE);
    bus.rd_data    = rd_q;
    bus.dec_en     = 1'b0;
    bus.dec_din    = '0;
    bus.bl_mode    = 2'b00;
    bus.sa_strobe  = 1'b0;
    case (state_q)
      S_SETUP, S_HOLD: bus.dec_din = row_q;
      S_PULSE: begin
        bus.dec_din   = row_q;
        bus.dec_en    = 1'b1;
        bus.bl_mode   = op_q;
        bus.sa_strobe = (op_q == OP_READ) && last_cyc;
      end
`ifdef RRAM_WRITE_VERIFY_EN
      S_VSETUP, S_VHOLD: bus.dec_din = row_q;
      S_VPULSE: begin
        bus.dec_din   = row_q;
        bus.dec_en    = 1'b1;
        bus.bl_mode   = OP_READ;
        bus.sa_strobe = last_cyc;
      end
`endif
      default: ;
    endcase
  end

`ifdef RRAM_WRITE_VERIFY_EN
  assign bus.done_status  = status_q;
  assign bus.done_retries = (retry_q > CNT_W'(3)) ? 2'd3 : retry_q[1:0];
`else
  assign bus.done_status  = 1'b0;
  assign bus.done_retries = 2'd0;
`endif
endmodule

// File: tb/tb_rram_row_sequencer.sv
// Bench for rram_row_sequencer: directed and random ops checked against a transaction-level model.
module tb_rram_row_sequencer;
  localparam int S = 2, R = 4, SW = 8, RW = 8, H = 1, MAXR = 3;
  localparam int BUDGET = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic last_rd = 1'b0;

  always #5 clk = ~clk;

  rram_row_sequencer_if bus();

  rram_row_sequencer #(
    .SETUP_CYC(S), .READ_CYC(R), .SET_CYC(SW), .RESET_CYC(RW),
    .HOLD_CYC(H), .CNT_W(8), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int   lat;
    int   wr;
    int   vr;
    int   st;
    logic status;
    int   retries;
    logic rd;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level expectation: phase lengths summed per attempt, verify outcome from sense-amp responses.
  function automatic exp_t model(input logic [1:0] op, input logic [3:0] resp, input logic prev_rd);
    exp_t e;
    int w, n;
    e = '{lat: 0, wr: 0, vr: 0, st: 0, status: 1'b0, retries: 0, rd: prev_rd};
    w = (op == 2'b10) ? SW : RW;
    if (op == 2'b00) e.lat = 1;
    else if (op == 2'b01) begin
      e.lat = S + R + H + 1; e.wr = R; e.st = 1; e.rd = resp[0];
    end else begin
`ifdef RRAM_WRITE_VERIFY_EN
      n = 0;
      for (int a = 0; a <= MAXR; a++) begin
        n = a + 1;
        e.rd = resp[a];
        if (resp[a] == (op == 2'b10)) begin e.status = 1'b0; break; end
        e.status = 1'b1;
      end
      e.lat = n * (S + w + H + S + R + H) + 1;
      e.wr = n * w; e.vr = n * R; e.st = n;
      e.retries = (n - 1 > 3) ? 3 : n - 1;
`else
      n = 1;
      e.lat = S + w + H + 1; e.wr = n * w;
`endif
    end
    return e;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [4:0] row, input logic [3:0] resp, input bit noisy);
    exp_t e;
    int c, en_c, wr_c, vr_c, st_c, bad, k;
    bit done, pend, en_prev;
    logic [4:0] din_prev;
    e = model(op, resp, last_rd);
    c = 0; en_c = 0; wr_c = 0; vr_c = 0; st_c = 0; bad = 0; k = 0;
    done = 0; pend = 0; en_prev = 0; din_prev = '0;
    @(negedge clk);
    chk("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    chk("done_one_cycle", {31'd0, bus.done_valid}, 32'd0);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_row = row; bus.sa_data = resp[0];
    @(posedge clk);
    while (!done && c < BUDGET) begin
      @(negedge clk);
      c++;
      if (noisy) begin bus.req_op = 2'($urandom); bus.req_row = 5'($urandom); end
      else bus.req_valid = 1'b0;
      if (pend) begin
        if (k < 4) bus.sa_data = resp[k];
        pend = 0;
      end
      if (bus.req_ready) bad++;
      if (c == 1 && op != 2'b00 && bus.dec_din !== row) bad++;
      if (bus.dec_en) begin
        en_c++;
        if (bus.dec_din !== row) bad++;
        if (en_prev && bus.dec_din !== din_prev) bad++;
        if (bus.bl_mode == op) wr_c++;
        else if (bus.bl_mode == 2'b01) vr_c++;
        else bad++;
      end else if (bus.bl_mode != 2'b00) bad++;
      if (bus.sa_strobe) begin
        st_c++;
        if (!bus.dec_en) bad++;
        k++; pend = 1;
      end
      en_prev = bus.dec_en; din_prev = bus.dec_din;
      if (bus.done_valid) done = 1;
    end
    bus.req_valid = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", c, e.lat);
    chk("wr_pulse_cyc", wr_c, e.wr);
    chk("vfy_pulse_cyc", vr_c, e.vr);
    chk("strobes", st_c, e.st);
    chk("protocol_violations", bad, 0);
    chk("done_status", {31'd0, bus.done_status}, {31'd0, e.status});
    chk("done_retries", {30'd0, bus.done_retries}, e.retries);
    chk("rd_data", {31'd0, bus.rd_data}, {31'd0, e.rd});
    last_rd = e.rd;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_dec_en", {31'd0, bus.dec_en}, 32'd0);
    chk("rst_dec_din", {27'd0, bus.dec_din}, 32'd0);
    chk("rst_bl_mode", {30'd0, bus.bl_mode}, 32'd0);
    chk("rst_strobe", {31'd0, bus.sa_strobe}, 32'd0);
    chk("rst_done", {31'd0, bus.done_valid}, 32'd0);
    chk("rst_status", {31'd0, bus.done_status}, 32'd0);
    chk("rst_rd", {31'd0, bus.rd_data}, 32'd0);
    chk("rst_retries", {30'd0, bus.done_retries}, 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_row = '0; bus.sa_data = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // Directed: READ row 5, then SET 31 / RESET 0 back-to-back, then NOP and READ with busy-time noise.
    run_op(2'b01, 5'd5, 4'b0001, 1'b0);
    run_op(2'b10, 5'd31, 4'b1111, 1'b0);
    run_op(2'b11, 5'd0, 4'b0000, 1'b0);
    run_op(2'b00, 5'd12, 4'b0000, 1'b1);
    run_op(2'b01, 5'd9, 4'b0000, 1'b1);
`ifdef RRAM_WRITE_VERIFY_EN
    run_op(2'b10, 5'd7, 4'b0100, 1'b0);
    chk("vfy_retries_2", {30'd0, bus.done_retries}, 32'd2);
    run_op(2'b11, 5'd3, 4'b1111, 1'b0);
    chk("vfy_fail_status", {31'd0, bus.done_status}, 32'd1);
    @(negedge clk);
    chk("vfy_back_idle", {31'd0, bus.req_ready}, 32'd1);
`endif

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), 5'($urandom), 4'($urandom), 1'($urandom));

    // Asynchronous reset in the middle of a SET pulse.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_row = 5'd17;
    @(posedge clk);
    repeat (S + 2) @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_pulse_en", {31'd0, bus.dec_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_dec_en", {31'd0, bus.dec_en}, 32'd0);
    chk("async_bl_mode", {30'd0, bus.bl_mode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    last_rd = 1'b0;
    run_op(2'b01, 5'd21, 4'b0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
